// File: rtl/fetch_unit_if.sv
// Program-memory read port of the fetch unit.
// The fetch side drives the request; memory answers with data and ready.
interface fetch_unit_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_rd,
    output mem_addr,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_rd,
    input  mem_addr,
    output mem_rdata,
    output mem_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch for the 8-bit multicycle core: PC, memory
// handshake with timeout, and a one-cycle IR write strobe.
module fetch_unit #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  fetch_unit_if.master      mem,
  output logic [DATA_W-1:0] instr_out,
  output logic              ir_write,
  output logic [ADDR_W-1:0] pc_out,
  output logic              fetch_busy,
  output logic              fetch_err
);

  localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pval_q, pval_d;
  logic              pend_q, pend_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic              err_q, err_d;
  logic              rd_q, rd_d;
  logic              irw_q, irw_d;
  logic              busy_q, busy_d;

  // A load arriving in the same cycle as WRITE or abort still wins.
  logic              ld_any;
  logic [ADDR_W-1:0] ld_val;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pval_d   = pval_q;
    pend_d   = pend_q;
    instr_d  = instr_q;
    wait_d   = wait_q;
    err_d    = err_q;
    ld_any   = pend_q | pc_load;
    ld_val   = pc_load ? pc_load_val : pval_q;

    unique case (state_q)
      IDLE: begin
        if (pc_load) begin
          pc_d = pc_load_val;
        end else if (fetch_req) begin
          state_d = REQ;
          err_d   = 1'b0;
          wait_d  = '0;
        end
      end
      REQ: begin
        pend_d = ld_any;
        pval_d = ld_val;
        if (mem.mem_ready) begin
          instr_d = mem.mem_rdata;
          state_d = WRITE;
        end else if (wait_q == LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
          pend_d  = 1'b0;
          if (ld_any) pc_d = ld_val;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      WRITE: begin
        pc_d    = ld_any ? ld_val : pc_q + ADDR_W'(1);
        pend_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    rd_d   = (state_d == REQ);
    irw_d  = (state_d == WRITE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      pval_q  <= '0;
      pend_q  <= 1'b0;
      instr_q <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      irw_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pval_q  <= pval_d;
      pend_q  <= pend_d;
      instr_q <= instr_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      irw_q   <= irw_d;
      busy_q  <= busy_d;
    end
  end

  assign mem.mem_rd   = rd_q;
  assign mem.mem_addr = pc_q;
  assign instr_out    = instr_q;
  assign ir_write     = irw_q;
  assign pc_out       = pc_q;
  assign fetch_busy   = busy_q;
  assign fetch_err    = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Fetch unit bench: transaction-level reference model, directed
// scenarios with literal checks, then randomized traffic.
module tb_fetch_unit;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int MW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          fetch_req = 1'b0;
  logic          pc_load = 1'b0;
  logic [AW-1:0] pc_load_val = '0;
  logic [DW-1:0] instr_out;
  logic          ir_write;
  logic [AW-1:0] pc_out;
  logic          fetch_busy;
  logic          fetch_err;

  fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) mif ();

  fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_req  (fetch_req),
    .pc_load    (pc_load),
    .pc_load_val(pc_load_val),
    .mem        (mif.master),
    .instr_out  (instr_out),
    .ir_write   (ir_write),
    .pc_out     (pc_out),
    .fetch_busy (fetch_busy),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Model: phase 0 idle, 1 waiting on memory, 2 delivering.
  int m_phase, m_waited, m_pc, m_instr, m_err, m_pend, m_pval;

  task automatic model_reset();
    m_phase = 0; m_waited = 0; m_pc = 0; m_instr = 0;
    m_err = 0; m_pend = 0; m_pval = 0;
  endtask

  task automatic model_step();
    if (m_phase == 0) begin
      if (pc_load) m_pc = pc_load_val;
      else if (fetch_req) begin
        m_phase = 1; m_waited = 0; m_err = 0;
      end
    end else begin
      if (pc_load) begin m_pend = 1; m_pval = pc_load_val; end
      if (m_phase == 2) begin
        m_pc = m_pend ? m_pval : (m_pc + 1) % 16;
        m_pend = 0; m_phase = 0;
      end else if (mif.mem_ready) begin
        m_instr = mif.mem_rdata; m_phase = 2;
      end else begin
        m_waited++;
        if (m_waited == MW) begin
          m_err = 1; m_phase = 0;
          if (m_pend) m_pc = m_pval;
          m_pend = 0;
        end
      end
    end
  endtask

  task automatic chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d want %0d", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("mem_rd", int'(mif.mem_rd), int'(m_phase == 1));
    chk("ir_write", int'(ir_write), int'(m_phase == 2));
    chk("busy", int'(fetch_busy), int'(m_phase != 0));
    chk("mem_addr", int'(mif.mem_addr), m_pc);
    chk("pc_out", int'(pc_out), m_pc);
    chk("instr", int'(instr_out), m_instr);
    chk("err", int'(fetch_err), m_err);
  endtask

  task automatic cycle(input logic fr, input logic pl,
                       input int plv, input logic rdy,
                       input int rd);
    fetch_req       = fr;
    pc_load         = pl;
    pc_load_val     = AW'(plv);
    mif.mem_ready   = rdy;
    mif.mem_rdata   = DW'(rd);
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    mif.mem_ready = 1'b0;
    mif.mem_rdata = '0;
    @(negedge clk);
    do_reset();
    chk("rst_pc", int'(pc_out), 0);
    chk("rst_instr", int'(instr_out), 0);

    // 1: basic fetch of 0xA3
    cycle(1, 0, 0, 0, 0);
    chk("t1_rd", int'(mif.mem_rd), 1);
    chk("t1_addr", int'(mif.mem_addr), 0);
    chk("t1_irw0", int'(ir_write), 0);
    cycle(0, 0, 0, 1, 'hA3);
    chk("t1_irw", int'(ir_write), 1);
    chk("t1_instr", int'(instr_out), 'hA3);
    cycle(0, 0, 0, 0, 0);
    chk("t1_irw_off", int'(ir_write), 0);
    chk("t1_pc", int'(pc_out), 1);

    // 2: load 15, fetch, wrap
    cycle(0, 1, 15, 0, 0);
    cycle(1, 0, 0, 0, 0);
    chk("t2_addr", int'(mif.mem_addr), 15);
    cycle(0, 0, 0, 1, 'h5C);
    cycle(0, 0, 0, 0, 0);
    chk("t2_instr", int'(instr_out), 'h5C);
    chk("t2_pc", int'(pc_out), 0);

    // 3a: ready after 3 wait cycles
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 0);
      chk("t3_rd_held", int'(mif.mem_rd), 1);
    end
    cycle(0, 0, 0, 1, 'h11);
    chk("t3_irw", int'(ir_write), 1);
    cycle(0, 0, 0, 0, 0);
    chk("t3_err0", int'(fetch_err), 0);
    chk("t3_pc", int'(pc_out), 1);

    // 3b: timeout after MAX_WAIT REQ cycles
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < MW - 1; i++) cycle(0, 0, 0, 0, 0);
    chk("t3_rd_last", int'(mif.mem_rd), 1);
    cycle(0, 0, 0, 0, 0);
    chk("t3_rd_abort", int'(mif.mem_rd), 0);
    chk("t3_err1", int'(fetch_err), 1);
    chk("t3_irw_abort", int'(ir_write), 0);
    chk("t3_pc_kept", int'(pc_out), 1);
    cycle(1, 0, 0, 0, 0);
    chk("t3_err_clr", int'(fetch_err), 0);
    cycle(0, 0, 0, 1, 'h22);
    cycle(0, 0, 0, 0, 0);

    // 4: load during REQ replaces increment
    cycle(0, 1, 4, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 9, 1, 'h77);
    chk("t4_irw", int'(ir_write), 1);
    chk("t4_addr", int'(mif.mem_addr), 4);
    cycle(0, 0, 0, 0, 0);
    chk("t4_pc", int'(pc_out), 9);

    // 5: load beats fetch in IDLE
    cycle(0, 1, 2, 0, 0);
    cycle(1, 1, 6, 0, 0);
    chk("t5_pc", int'(pc_out), 6);
    chk("t5_nord", int'(mif.mem_rd), 0);
    cycle(1, 0, 0, 0, 0);
    chk("t5_addr", int'(mif.mem_addr), 6);
    cycle(0, 0, 0, 1, 'h66);
    cycle(0, 0, 0, 0, 0);

    // 6: reset mid-REQ, then fetch_req held through WRITE
    cycle(1, 0, 0, 0, 0);
    do_reset();
    chk("t6_rd", int'(mif.mem_rd), 0);
    chk("t6_instr", int'(instr_out), 0);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 'h3C);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk("t6_no_refetch", int'(mif.mem_rd), 0);
    chk("t6_pc", int'(pc_out), 1);

    // randomized traffic with varying memory responsiveness
    for (int b = 0; b < 12; b++) begin
      int rdy_pct;
      rdy_pct = (b % 4 == 0) ? 0 : int'($urandom_range(15, 100));
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(0, 299) == 0) do_reset();
        cycle(logic'($urandom_range(0, 2) == 0),
              logic'($urandom_range(0, 5) == 0),
              int'($urandom_range(0, 15)),
              logic'(int'($urandom_range(1, 100)) <= rdy_pct),
              int'($urandom_range(0, 255)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch side of the 8-bit multicycle core. Holds the program counter, reads the instruction byte from program memory with a ready handshake, and delivers it to the instruction register together with a one-cycle `ir_write` strobe. Sits between the control FSM, which issues fetch and PC-load commands, and the instruction register plus program memory.

Parameters:
- ADDR_W, 4, program-counter and memory-address width.
- DATA_W, 8, instruction width.
- MAX_WAIT, 8, maximum cycles in REQ waiting for `mem_ready` before abort; must be at least 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- fetch_req  in  1  control FSM request to fetch the instruction at PC.
- pc_load  in  1  load PC with `pc_load_val` (branch/jump).
- pc_load_val  in  ADDR_W  new PC value.
- mem_rd  out  1  memory read strobe.
- mem_addr  out  ADDR_W  memory address; equals PC.
- mem_rdata  in  DATA_W  memory read data; valid when `mem_ready`=1.
- mem_ready  in  1  memory data valid.
- instr_out  out  DATA_W  registered instruction byte, drives IR input.
- ir_write  out  1  one-cycle IR load strobe.
- pc_out  out  ADDR_W  current PC.
- fetch_busy  out  1  high in REQ and WRITE.
- fetch_err  out  1  sticky timeout flag.

Behaviour:
- Reset is clk and reset, asynchronous, active-high. While reset is high:
  - state=IDLE
  - pc=0, instr_out=0, mem_rd=0, ir_write=0, fetch_err=0
  - wait counter=0, pending-load flag=0
- Reset mid-fetch aborts with no `ir_write`.
- `mem_addr` = pc at all times. `pc_out` = pc.
- States: IDLE, REQ, WRITE. All outputs are registered or decoded from state; no combinational path from inputs to `ir_write`.
- IDLE:
  - `pc_load`=1: pc <= pc_load_val. This takes priority over `fetch_req`, which is ignored that cycle.
  - Otherwise, `fetch_req`=1: go to REQ, clear `fetch_err`, clear wait counter.
- REQ:
  - mem_rd=1 and fetch_busy=1.
  - `mem_ready`=1: instr_out <= mem_rdata, go to WRITE.
  - Otherwise the wait counter increments. If the counter reaches MAX_WAIT-1 without `mem_ready`: set fetch_err=1, return to IDLE, no `ir_write`, PC unchanged.
- WRITE:
  - ir_write=1 for exactly one cycle, mem_rd=0, fetch_busy=1.
  - `instr_out` stays stable through this cycle and after it.
  - Next pc: pending-load value if pending, else pc+1 modulo 2^ADDR_W (15 wraps to 0).
  - Clear pending flag, go to IDLE.
- `pc_load` during REQ or WRITE:
  - Latch `pc_load_val` into the pending register and set the pending flag. The last load wins.
  - Applied at WRITE instead of the increment.
  - On a timeout abort, the pending load is applied when returning to IDLE.
- `fetch_req` while busy is ignored; no queuing.
- Latency: with `mem_ready` held high, `fetch_req` at cycle N gives mem_rd at N+1, ir_write at N+2, and the incremented pc visible at N+3. Back-to-back fetches run one per 3 cycles.
- `instr_out` updates only on an accepted `mem_ready` in REQ. `mem_ready` in other states is ignored.
- `fetch_err` stays high until the next accepted `fetch_req` or reset.

Test Plan:
1. Reset, then `fetch_req` pulse with memory returning 0xA3, `mem_ready` same cycle as `mem_rd` → mem_addr=0, ir_write high exactly one cycle two cycles after req, instr_out=0xA3, pc_out=1 afterwards.
2. pc_load with val=15 in IDLE, then a fetch (data 0x5C) → mem_addr=15, instr_out=0x5C, pc wraps to 0.
3. Memory delays `mem_ready` 3 cycles (MAX_WAIT=8) → mem_rd held 4 cycles, single ir_write, fetch_err=0. `mem_ready` withheld entirely → fetch_err=1 after 8 REQ cycles, no ir_write, pc unchanged. Next `fetch_req` clears fetch_err.
4. `pc_load` val=9 asserted during REQ at pc=4 → fetch completes from address 4, pc becomes 9 (not 5).
5. Simultaneous `pc_load` val=6 and `fetch_req` in IDLE at pc=2 → pc=6, no mem_rd that cycle. Subsequent `fetch_req` reads address 6.
6. Assert reset while in REQ → mem_rd drops immediately, pc=0, instr_out=0, no ir_write. `fetch_req` held during WRITE is not re-fetched.
